// File: rtl/serial_thermometer_generator_if.sv
// Handshake and serial-lane bundle for the serial thermometer generator.
// master = upstream/serial consumer side, slave = the generator.
interface serial_thermometer_generator_if #(
   parameter int SERIAL_INPUT_LENGTH = 64,
   parameter int VW = $clog2(SERIAL_INPUT_LENGTH) + 2
);
   logic signed [VW-1:0] value_in;
   logic                 in_valid;
   logic                 in_ready;
   logic                 serial_en;
   logic                 serial_out;
   logic                 serial_valid;
   logic                 serial_last;
   logic                 sat_flag;

   modport master (
      output value_in, in_valid, serial_en,
      input  in_ready, serial_out, serial_valid,
      input  serial_last, sat_flag
   );

   modport slave (
      input  value_in, in_valid, serial_en,
      output in_ready, serial_out, serial_valid,
      output serial_last, sat_flag
   );
endinterface

// File: rtl/serial_thermometer_generator.sv
// Signed value -> L-bit serial thermometer frame (value+L/2 ones, then zeros).
// One frame per accepted value; back-to-back frames abut with no gap.
module serial_thermometer_generator #(
   parameter int SERIAL_INPUT_LENGTH = 64,
   parameter int CW = $clog2(SERIAL_INPUT_LENGTH) + 1,
   parameter int VW = $clog2(SERIAL_INPUT_LENGTH) + 2
) (
   input logic clk,
   input logic rst,
   serial_thermometer_generator_if.slave th
);
   localparam int L = SERIAL_INPUT_LENGTH;
   localparam logic signed [VW:0] HALF = (VW+1)'(L / 2);
   localparam logic signed [VW:0] FULL = (VW+1)'(L);
   localparam logic [CW-1:0] K_LAST = CW'(L - 1);
   localparam logic [CW-1:0] ONES_MAX = CW'(L);

   typedef enum logic {IDLE, SEND} state_e;

   state_e state_q, state_d;
   logic [CW-1:0] k_q, k_d;
   logic [CW-1:0] ones_q, ones_d;
   logic sat_q, sat_d;
   logic out_q, out_d;
   logic last_q, last_d;

   logic signed [VW:0] sum;
   logic [CW-1:0] ones_new;
   logic sat_new;
   logic [CW-1:0] k_nxt;
   logic at_end;
   logic ready;
   logic accept;

   // Clamp out-of-range values to an all-zero or all-one frame.
   always_comb begin
      sum = $signed({th.value_in[VW-1], th.value_in}) + HALF;
      ones_new = '0;
      sat_new = 1'b0;
      unique case (1'b1)
         (sum < 0): begin
            ones_new = '0;
            sat_new = 1'b1;
         end
         (sum > FULL): begin
            ones_new = ONES_MAX;
            sat_new = 1'b1;
         end
         default: begin
            ones_new = CW'(sum);
            sat_new = 1'b0;
         end
      endcase
   end

   assign k_nxt = k_q + CW'(1);
   assign at_end = (state_q == SEND) && (k_q == K_LAST) && th.serial_en;
   assign accept = th.in_valid && ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (accept) state_d = SEND;
         SEND: if (at_end && !accept) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      ready = 1'b0;
      if (!rst) ready = (state_q == IDLE) || at_end;
      th.in_ready = ready;
      th.serial_valid = (state_q == SEND);
      th.serial_out = out_q;
      th.serial_last = last_q;
      th.sat_flag = sat_q;
   end

   // Bit k of the frame is precomputed so serial_out is a flop output.
   always_comb begin
      k_d = k_q;
      ones_d = ones_q;
      sat_d = sat_q;
      out_d = out_q;
      last_d = last_q;
      if (accept) begin
         k_d = '0;
         ones_d = ones_new;
         sat_d = sat_new;
         out_d = (ones_new != '0);
         last_d = 1'b0;
      end else if ((state_q == SEND) && th.serial_en) begin
         if (at_end) begin
            k_d = '0;
            out_d = 1'b0;
            last_d = 1'b0;
         end else begin
            k_d = k_nxt;
            out_d = (k_nxt < ones_q);
            last_d = (k_nxt == K_LAST);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         k_q <= '0;
         ones_q <= '0;
         sat_q <= 1'b0;
         out_q <= 1'b0;
         last_q <= 1'b0;
      end else begin
         k_q <= k_d;
         ones_q <= ones_d;
         sat_q <= sat_d;
         out_q <= out_d;
         last_q <= last_d;
      end
   end
endmodule

// File: tb/tb_serial_thermometer_generator.sv
// Directed bench for serial_thermometer_generator (L=64).
// Inputs change on the falling edge; outputs sampled 1ns later.
module tb_serial_thermometer_generator;
   localparam int L = 64;
   localparam int VW = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int tests = 0;
   int failed = 0;

   serial_thermometer_generator_if #(.SERIAL_INPUT_LENGTH(L)) th ();

   serial_thermometer_generator #(.SERIAL_INPUT_LENGTH(L)) dut (
      .clk(clk),
      .rst(rst),
      .th(th)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] mask(input int ones);
      logic [63:0] m;
      m = '1;
      if (ones < 64) m = (64'd1 << ones) - 64'd1;
      return m;
   endfunction

   // Runs one frame from the cycle its bit 0 is visible.
   task automatic capture(input int sa, input int sb, input bit hold,
                          output logic [63:0] bits, output int cyc,
                          output int nlast, output int lpos,
                          output int errs, output logic satv);
      int k;
      int c;
      bit sad, sbd, en, pend;
      logic pbit, plast;
      k = 0; c = 0; sad = 0; sbd = 0; pend = 0;
      pbit = 0; plast = 0;
      bits = '0; nlast = 0; lpos = -1; errs = 0; satv = 1'bx;
      while (k < L && c < 300) begin
         en = 1;
         if (k == sa && !sad) begin
            en = 0; sad = 1;
         end else if (k == sb && !sbd) begin
            en = 0; sbd = 1;
         end
         th.serial_en = en;
         if (hold) begin
            th.in_valid = (k != L - 1);
            th.value_in = VW'(-32);
         end
         #1;
         if (th.serial_valid !== 1'b1) errs++;
         if (th.in_ready !== ((k == L - 1) && en)) errs++;
         if (c == 0) satv = th.sat_flag;
         else if (th.sat_flag !== satv) errs++;
         if (pend && (th.serial_out !== pbit || th.serial_last !== plast))
            errs++;
         pend = !en;
         pbit = th.serial_out;
         plast = th.serial_last;
         if (en) begin
            bits[k] = th.serial_out;
            if (th.serial_last) begin
               nlast++;
               lpos = k;
            end
            k++;
         end
         @(posedge clk);
         @(negedge clk);
         c++;
      end
      th.serial_en = 1'b1;
      cyc = c;
   endtask

   task automatic check_frame(input string tag, input logic [63:0] bits,
                              input int cyc, input int nlast,
                              input int lpos, input int errs,
                              input logic satv, input int exp_ones,
                              input logic exp_sat, input int exp_cyc);
      chk({tag, "_bits"}, bits, mask(exp_ones));
      chk({tag, "_ones"}, 64'($countones(bits)), 64'(exp_ones));
      chk({tag, "_cyc"}, 64'(cyc), 64'(exp_cyc));
      chk({tag, "_nlast"}, 64'(nlast), 64'd1);
      chk({tag, "_lpos"}, 64'(lpos), 64'(L - 1));
      chk({tag, "_errs"}, 64'(errs), 64'd0);
      chk({tag, "_sat"}, 64'(satv), 64'(exp_sat));
   endtask

   task automatic do_frame(input string tag, input int v,
                           input int exp_ones, input logic exp_sat,
                           input int sa, input int sb, input bit hold,
                           input int exp_cyc);
      logic [63:0] bits;
      int cyc, nlast, lpos, errs;
      logic satv;
      th.value_in = VW'(v);
      th.in_valid = 1'b1;
      th.serial_en = 1'b1;
      #1;
      chk({tag, "_rdy"}, 64'(th.in_ready), 64'd1);
      chk({tag, "_idle_v"}, 64'(th.serial_valid), 64'd0);
      @(posedge clk);
      @(negedge clk);
      if (!hold) th.in_valid = 1'b0;
      capture(sa, sb, hold, bits, cyc, nlast, lpos, errs, satv);
      check_frame(tag, bits, cyc, nlast, lpos, errs, satv,
                  exp_ones, exp_sat, exp_cyc);
      if (!exp_sat)
         chk({tag, "_rt"}, 64'($countones(bits) - L / 2), 64'(v));
      #1;
      chk({tag, "_end_v"}, 64'(th.serial_valid), 64'd0);
   endtask

   initial begin
      logic [63:0] bits;
      int cyc, nlast, lpos, errs;
      logic satv;

      th.value_in = '0;
      th.in_valid = 1'b0;
      th.serial_en = 1'b1;

      repeat (3) @(negedge clk);
      #1;
      chk("rst_valid", 64'(th.serial_valid), 64'd0);
      chk("rst_out", 64'(th.serial_out), 64'd0);
      chk("rst_last", 64'(th.serial_last), 64'd0);
      chk("rst_sat", 64'(th.sat_flag), 64'd0);
      chk("rst_ready", 64'(th.in_ready), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rel_ready", 64'(th.in_ready), 64'd1);

      // Mid-frame reset at k=10
      @(negedge clk);
      th.value_in = VW'(0);
      th.in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      th.in_valid = 1'b0;
      repeat (10) begin
         @(posedge clk);
         @(negedge clk);
      end
      #1;
      chk("mid_pre_out", 64'(th.serial_out), 64'd1);
      rst = 1'b1;
      #1;
      chk("mid_valid", 64'(th.serial_valid), 64'd0);
      chk("mid_out", 64'(th.serial_out), 64'd0);
      chk("mid_last", 64'(th.serial_last), 64'd0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("mid_ready", 64'(th.in_ready), 64'd1);
      errs = 0;
      repeat (80) begin
         @(posedge clk);
         #1;
         if (th.serial_valid !== 1'b0 || th.serial_out !== 1'b0) errs++;
      end
      chk("mid_residual", 64'(errs), 64'd0);
      @(negedge clk);

      do_frame("zero", 0, 32, 1'b0, -1, -1, 1'b0, 64);
      @(negedge clk);
      do_frame("m32", -32, 0, 1'b0, -1, -1, 1'b0, 64);
      @(negedge clk);
      do_frame("p32", 32, 64, 1'b0, -1, -1, 1'b0, 64);
      @(negedge clk);
      do_frame("m50", -50, 0, 1'b1, -1, -1, 1'b0, 64);
      @(negedge clk);
      do_frame("p100", 100, 64, 1'b1, -1, -1, 1'b0, 64);
      @(negedge clk);
      do_frame("stall", 7, 39, 1'b0, 20, 38, 1'b0, 66);

      // Back-to-back: 5 then -3 held until taken in the bit-63 cycle
      @(negedge clk);
      th.value_in = VW'(5);
      th.in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      th.value_in = VW'(-3);
      capture(-1, -1, 1'b0, bits, cyc, nlast, lpos, errs, satv);
      check_frame("b2b1", bits, cyc, nlast, lpos, errs, satv,
                  37, 1'b0, 64);
      th.in_valid = 1'b0;
      capture(-1, -1, 1'b0, bits, cyc, nlast, lpos, errs, satv);
      check_frame("b2b2", bits, cyc, nlast, lpos, errs, satv,
                  29, 1'b0, 64);
      #1;
      chk("b2b_end_v", 64'(th.serial_valid), 64'd0);

      // Round trip with in_valid held through SEND
      for (int v = -32; v <= 32; v++) begin
         @(negedge clk);
         do_frame("sweep", v, v + 32, 1'b0, -1, -1, 1'b1, 64);
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
